// File: rtl/clk_div_pkg.sv
// Shared types and constants for the run-time clock-divider controller.
package clk_div_pkg;

  // Controller states: stopped, counting, counting with a queued request.
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  // Smallest divide ratio that produces a real clock.
  localparam int unsigned DIV_MIN = 2;

endpackage

// File: rtl/clk_div_core.sv
// Divide counter and clk_out flop. The counter wraps at i_div-1. clk_out is
// loaded from the next-cycle counter and ratio, so it lines up with cnt.
module clk_div_core #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,     // force cnt to 0 next cycle
  input  logic             i_run,      // counting this cycle
  input  logic [CNT_W-1:0] i_div,      // ratio in effect this cycle
  input  logic             i_out_en,   // divider running next cycle
  input  logic [CNT_W-1:0] i_out_div,  // ratio in effect next cycle
  output logic             o_wrap,
  output logic             o_first,
  output logic             o_clk_out
);

  localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   ONE_XC = {{CNT_W{1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;
  logic             r_clk_out;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W:0]   w_low_len;
  logic             w_wrap;

  // cur_div is never below 2, so i_div-1 cannot underflow.
  assign w_wrap    = (r_cnt == (i_div - ONE_C));
  // Length of the low phase, ceil(N/2), one bit wider so N=2^CNT_W-1 fits.
  assign w_low_len = ({1'b0, i_out_div} + ONE_XC) >> 1;

  // Next counter value: load, count with wrap, or hold while stopped.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_load) begin
      w_cnt_nxt = '0;
    end else if (i_run) begin
      if (w_wrap) begin
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt + ONE_C;
      end
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Counter and divided-clock flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_clk_out <= i_out_en && ({1'b0, w_cnt_nxt} >= w_low_len);
    end
  end

  assign o_wrap    = w_wrap;
  assign o_first   = (r_cnt == '0);
  assign o_clk_out = r_clk_out;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the integer clock divider. It takes ratio and enable
// requests over valid/ready. Ratio changes and stops take effect only at a
// period boundary, so clk_out never emits a runt pulse.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int DIV_RESET = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [CNT_W-1:0] i_cfg_div,
  input  logic             i_cfg_en,
  output logic             o_cfg_err,
  output logic             o_clk_out,
  output logic             o_period_start,
  output logic [CNT_W-1:0] o_cur_div,
  output logic             o_active
);

  localparam logic [CNT_W-1:0] DIV_MIN_C   = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] DIV_RESET_C = CNT_W'(DIV_RESET);

  state_t           r_state;
  logic [CNT_W-1:0] r_cur_div;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_pend_en;
  logic             r_cfg_ready;
  logic             r_cfg_err;
  logic             r_active;

  logic             w_xfer;
  logic             w_bad;
  logic             w_start;
  logic             w_reject;
  logic             w_latch;
  logic             w_swap;
  logic             w_stop;
  logic             w_run_nxt;
  logic [CNT_W-1:0] w_div_nxt;
  logic             w_core_wrap;
  logic             w_core_first;
  logic             w_core_clk;

  assign w_xfer = i_cfg_valid && r_cfg_ready;
  assign w_bad  = i_cfg_en && (i_cfg_div < DIV_MIN_C);

  // Decide this cycle's transition events and the next-cycle run/ratio view.
  always_comb begin
    w_start   = 1'b0;
    w_reject  = 1'b0;
    w_latch   = 1'b0;
    w_swap    = 1'b0;
    w_stop    = 1'b0;
    w_run_nxt = 1'b0;
    w_div_nxt = r_cur_div;
    case (r_state)
      ST_OFF: begin
        w_reject = w_xfer && w_bad;
        if (w_xfer && i_cfg_en && !w_bad) begin
          w_start   = 1'b1;
          w_run_nxt = 1'b1;
          w_div_nxt = i_cfg_div;
        end else begin
          w_run_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        w_run_nxt = 1'b1;
        w_reject  = w_xfer && w_bad;
        if (w_xfer && !w_bad) begin
          w_latch = 1'b1;
        end else begin
          w_latch = 1'b0;
        end
      end
      ST_PEND: begin
        if (w_core_wrap) begin
          if (r_pend_en) begin
            w_swap    = 1'b1;
            w_run_nxt = 1'b1;
            w_div_nxt = r_pend_div;
          end else begin
            w_stop    = 1'b1;
            w_run_nxt = 1'b0;
          end
        end else begin
          w_run_nxt = 1'b1;
        end
      end
      default: begin
        w_run_nxt = 1'b0;
      end
    endcase
  end

  // Controller FSM with handshake, pending request and registered status.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_OFF;
      r_cur_div   <= DIV_RESET_C;
      r_pend_div  <= DIV_RESET_C;
      r_pend_en   <= 1'b0;
      r_cfg_ready <= 1'b1;
      r_cfg_err   <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_cfg_err <= w_reject;
      r_active  <= w_run_nxt;
      r_cur_div <= w_div_nxt;
      case (r_state)
        ST_OFF: begin
          r_cfg_ready <= 1'b1;
          if (w_start) begin
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_OFF;
          end
        end
        ST_RUN: begin
          if (w_latch) begin
            r_pend_div  <= i_cfg_div;
            r_pend_en   <= i_cfg_en;
            r_state     <= ST_PEND;
            r_cfg_ready <= 1'b0;
          end else begin
            r_state     <= ST_RUN;
            r_cfg_ready <= 1'b1;
          end
        end
        ST_PEND: begin
          if (w_swap) begin
            r_state     <= ST_RUN;
            r_cfg_ready <= 1'b1;
          end else if (w_stop) begin
            r_state     <= ST_OFF;
            r_cfg_ready <= 1'b1;
          end else begin
            r_state     <= ST_PEND;
            r_cfg_ready <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_OFF;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_start),
    .i_run     (r_state != ST_OFF),
    .i_div     (r_cur_div),
    .i_out_en  (w_run_nxt),
    .i_out_div (w_div_nxt),
    .o_wrap    (w_core_wrap),
    .o_first   (w_core_first),
    .o_clk_out (w_core_clk)
  );

  assign o_cfg_ready    = r_cfg_ready;
  assign o_cfg_err      = r_cfg_err;
  assign o_clk_out      = w_core_clk;
  assign o_period_start = r_active && w_core_first;
  assign o_cur_div      = r_cur_div;
  assign o_active       = r_active;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: a table of ratios checked from a cold
// start, plus hand-written sequences for ratio change, rejection, stop,
// request-at-wrap and reset mid-period.
module tb_clk_div_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_div;
  logic       cfg_en;
  logic       cfg_err;
  logic       clk_out;
  logic       period_start;
  logic [7:0] cur_div;
  logic       active;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] div;
    int         exp_low;
    int         exp_high;
  } vec_t;

  vec_t vecs [6];

  clk_div_ctrl #(.CNT_W(8), .DIV_RESET(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_cfg_valid    (cfg_valid),
    .o_cfg_ready    (cfg_ready),
    .i_cfg_div      (cfg_div),
    .i_cfg_en       (cfg_en),
    .o_cfg_err      (cfg_err),
    .o_clk_out      (clk_out),
    .o_period_start (period_start),
    .o_cur_div      (cur_div),
    .o_active       (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_ready"}, int'(cfg_ready), 1);
    chk({name, "_err"},   int'(cfg_err), 0);
    chk({name, "_clk"},   int'(clk_out), 0);
    chk({name, "_ps"},    int'(period_start), 0);
    chk({name, "_div"},   int'(cur_div), 4);
    chk({name, "_act"},   int'(active), 0);
  endtask

  task automatic do_reset;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;
    cfg_en    = 1'b0;
    rst       = 1'b1;
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;
  endtask

  // Present a request, wait for ready (bounded), let it transfer.
  task automatic send(input logic [7:0] div, input logic en);
    int n;
    cfg_valid = 1'b1;
    cfg_div   = div;
    cfg_en    = en;
    n = 0;
    while (!cfg_ready && n < 600) begin
      tick();
      n++;
    end
    chk("send_ready", int'(cfg_ready), 1);
    tick();
    cfg_valid = 1'b0;
  endtask

  // Check one full period starting at the current (cnt==0) cycle.
  task automatic check_period(input int low, input int high, input string name);
    for (int i = 0; i < low + high; i++) begin
      chk({name, "_clk"}, int'(clk_out), (i >= low) ? 1 : 0);
      chk({name, "_ps"},  int'(period_start), (i == 0) ? 1 : 0);
      chk({name, "_act"}, int'(active), 1);
      tick();
    end
  endtask

  initial begin
    vecs[0] = '{div: 8'd4,   exp_low: 2,   exp_high: 2};
    vecs[1] = '{div: 8'd5,   exp_low: 3,   exp_high: 2};
    vecs[2] = '{div: 8'd2,   exp_low: 1,   exp_high: 1};
    vecs[3] = '{div: 8'd3,   exp_low: 2,   exp_high: 1};
    vecs[4] = '{div: 8'd255, exp_low: 128, exp_high: 127};
    vecs[5] = '{div: 8'd8,   exp_low: 4,   exp_high: 4};

    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;
    cfg_en    = 1'b0;

    // Table: start each ratio from OFF and check two full periods.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      send(vecs[v].div, 1'b1);
      chk("tbl_div", int'(cur_div), int'(vecs[v].div));
      chk("tbl_ready", int'(cfg_ready), 1);
      check_period(vecs[v].exp_low, vecs[v].exp_high, "tbl_p1");
      check_period(vecs[v].exp_low, vecs[v].exp_high, "tbl_p2");
    end

    // OFF: en=0 is a no-op; en=1 with div<2 is rejected.
    do_reset();
    send(8'd7, 1'b0);
    chk("off_noop_act", int'(active), 0);
    chk("off_noop_div", int'(cur_div), 4);
    chk("off_noop_err", int'(cfg_err), 0);
    send(8'd0, 1'b1);
    chk("off_rej_err", int'(cfg_err), 1);
    chk("off_rej_act", int'(active), 0);
    tick();
    chk("off_rej_err_clr", int'(cfg_err), 0);

    // Ratio change 6 -> 3 requested at cnt=1.
    do_reset();
    send(8'd6, 1'b1);
    chk("chg_div6", int'(cur_div), 6);
    chk("chg_c0_clk", int'(clk_out), 0);
    tick();
    chk("chg_c1_clk", int'(clk_out), 0);
    cfg_valid = 1'b1;
    cfg_div   = 8'd3;
    cfg_en    = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int c = 2; c < 6; c++) begin
      chk("chg_pend_ready", int'(cfg_ready), 0);
      chk("chg_pend_clk", int'(clk_out), (c >= 3) ? 1 : 0);
      chk("chg_pend_div", int'(cur_div), 6);
      tick();
    end
    chk("chg_new_div", int'(cur_div), 3);
    chk("chg_new_ready", int'(cfg_ready), 1);
    check_period(2, 1, "chg_p1");
    check_period(2, 1, "chg_p2");

    // Rejection while running at div=4.
    do_reset();
    send(8'd4, 1'b1);
    cfg_valid = 1'b1;
    cfg_div   = 8'd1;
    cfg_en    = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("rej_err", int'(cfg_err), 1);
    chk("rej_ready", int'(cfg_ready), 1);
    chk("rej_div", int'(cur_div), 4);
    chk("rej_c1_clk", int'(clk_out), 0);
    tick();
    chk("rej_err_once", int'(cfg_err), 0);
    chk("rej_c2_clk", int'(clk_out), 1);
    tick();
    chk("rej_c3_clk", int'(clk_out), 1);
    tick();
    check_period(2, 2, "rej_after");

    // Stop requested at cnt=0 of a div=4 period.
    do_reset();
    send(8'd4, 1'b1);
    cfg_valid = 1'b1;
    cfg_div   = 8'd0;
    cfg_en    = 1'b0;
    tick();
    cfg_valid = 1'b0;
    chk("stop_err", int'(cfg_err), 0);
    chk("stop_ready", int'(cfg_ready), 0);
    chk("stop_c1_clk", int'(clk_out), 0);
    tick();
    chk("stop_c2_clk", int'(clk_out), 1);
    tick();
    chk("stop_c3_clk", int'(clk_out), 1);
    chk("stop_c3_act", int'(active), 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("stop_off_clk", int'(clk_out), 0);
      chk("stop_off_act", int'(active), 0);
      chk("stop_off_ps", int'(period_start), 0);
      chk("stop_off_ready", int'(cfg_ready), 1);
      tick();
    end

    // Request arriving on the wrap cycle waits a full period.
    do_reset();
    send(8'd4, 1'b1);
    tick();
    tick();
    tick();
    cfg_valid = 1'b1;
    cfg_div   = 8'd2;
    cfg_en    = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("wrapreq_ready", int'(cfg_ready), 0);
    chk("wrapreq_div", int'(cur_div), 4);
    check_period(2, 2, "wrapreq_old");
    chk("wrapreq_new_div", int'(cur_div), 2);
    check_period(1, 1, "wrapreq_new");

    // Reset during the high phase at div=8.
    do_reset();
    send(8'd8, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk("rstmid_clk_hi", int'(clk_out), 1);
    rst = 1'b1;
    tick();
    chk_reset_vals("rstmid");
    rst = 1'b0;
    tick();
    chk("rstmid_idle_act", int'(active), 0);
    chk("rstmid_idle_clk", int'(clk_out), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time controller for the integer clock-divider datapath. It accepts divide-ratio and enable requests over a valid/ready handshake and runs the divide counter. Ratio changes and stops are applied only at a period boundary, so `clk_out` never produces a runt pulse. It sits between the configuration register interface and any logic that consumes the divided clock or its per-period tick.

## Interface
- `CNT_W`, 8: width of the divide counter and ratio; legal ratios are 2..2^CNT_W-1.
- `DIV_RESET`, 4: value loaded into `cur_div` at reset.
- `clk`  in  1  reference clock; every flop is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  configuration request valid.
- `cfg_ready`  out  1  controller can accept a request.
- `cfg_div`  in  CNT_W  requested divide ratio N.
- `cfg_en`  in  1  1 = run at `cfg_div`; 0 = stop.
- `cfg_err`  out  1  one-cycle pulse when a request is rejected.
- `clk_out`  out  1  divided clock, driven by a flop.
- `period_start`  out  1  high in the first cycle of each divided period.
- `cur_div`  out  CNT_W  ratio currently in effect.
- `active`  out  1  divider is running (state is not OFF).

## Operation
- States: OFF, RUN, PEND. Internal registers: `cnt` (CNT_W bits), `pend_div`, `pend_en`.
- Values after reset: state OFF, `cnt`=0, `clk_out`=0, `cur_div`=DIV_RESET, `cfg_ready`=1, `cfg_err`=0, `period_start`=0, `active`=0. Reset has priority over every other event.
- Handshake:
  - `cfg_ready` = 1 in OFF and RUN, 0 in PEND.
  - A request transfers in any cycle where `cfg_valid` && `cfg_ready`.
  - The requester holds `cfg_valid` and its data stable until the transfer.
- Rejection:
  - A transferred request with `cfg_en`=1 and `cfg_div`<2 is consumed and discarded.
  - `cfg_err` pulses in the following cycle.
  - State, `cur_div` and `cnt` are unchanged.
- OFF:
  - An accepted valid request with `cfg_en`=1 does `cur_div`<=`cfg_div`, `cnt`<=0, next state RUN.
  - An accepted request with `cfg_en`=0 is a no-op.
- RUN:
  - `cnt` increments every cycle and wraps from `cur_div`-1 to 0.
  - An accepted valid request latches `pend_div` and `pend_en`, next state PEND.
- PEND:
  - Counting continues unchanged.
  - In the cycle where `cnt` = `cur_div`-1, with `pend_en`=1: `cur_div`<=`pend_div`, `cnt`<=0, next state RUN.
  - In the same cycle, with `pend_en`=0: `cnt`<=0, next state OFF.
- Output rule, with L = ceil(`cur_div`/2):
  - In RUN and PEND, `clk_out` = (`cnt` >= L) in the same cycle. The flop is loaded from the next-state values of `cnt` and `cur_div`.
  - In OFF, `clk_out` = 0.
  - Result: low for ceil(N/2) cycles, then high for floor(N/2) cycles; 50% duty for even N.
- `period_start` = (state is not OFF) && `cnt`==0.
- `active` = (state is not OFF).
- Arithmetic:
  - The comparison `cnt` == `cur_div`-1 is computed at CNT_W bits; `cur_div` is never below 2, so there is no underflow.
  - L is computed as (`cur_div`+1)>>1 at CNT_W+1 bits, so `cur_div` = 2^CNT_W-1 gives no overflow.

## Timing
- Start latency: request accepted at edge k means cycle k+1 has `cnt`=0, `period_start`=1, `clk_out`=0. The first rising edge of `clk_out` is at cycle k+1+L.
- A change requested mid-period takes effect at the next wrap. The new period always begins low, so there is no glitch at the ratio boundary.
- Stop: `clk_out` finishes its full high phase, then stays 0. `active` falls in the cycle after the last count.
- A request arriving in the same cycle as a wrap while in RUN is treated as mid-period: it waits for the next wrap.
- Back-to-back requests are possible: `cfg_ready` returns to 1 in the first cycle of the new period.
- Reset mid-period: `clk_out` goes to 0 in the cycle after `rst` is sampled high, even if that truncates a high phase.

## Structure
- Package `clk_div_pkg`:
  - typedef of the state enum {OFF, RUN, PEND};
  - constant `DIV_MIN`=2.
- Sub-module `clk_div_core`:
  - contains `cnt` and the `clk_out` flop;
  - inputs `load` (force `cnt`=0), `run`, `div`;
  - outputs `wrap` and `first`.
- The FSM, handshake and pending registers live in `clk_div_ctrl`.

## Test plan
- After reset, request div=4 en=1 → `clk_out` pattern 0,0,1,1 repeating; `period_start` every 4 cycles; `active`=1.
- Request div=5 → low 3 cycles, high 2 cycles. Then div=2^CNT_W-1=255 → low 128 cycles, high 127 cycles.
- Running at div=6, request div=3 at `cnt`=1 → `cfg_ready`=0 until the wrap; 6-cycle period completes; next period is 0,0,1; `cur_div` becomes 3 in the cycle `cnt`=0.
- Request div=1 (en=1) while running at div=4 → `cfg_err` pulses once; output unchanged; `cfg_ready` stays 1.
- Running at div=4, request en=0 at `cnt`=0 → the 0,0,1,1 period completes, then `clk_out`=0 and `active`=0 from the next cycle.
- Assert `rst` for 1 cycle while `clk_out`=1 at div=8 → next cycle all outputs are at their reset values and `cur_div`=DIV_RESET.
